// File: rtl/lbfr_read_ctrl.sv
// lbfr_read_ctrl: arbitrated line-buffer read controller producing framed payload beats.
// Optional CRC-16 trailer beat is built when LBFR_READ_CTRL_CRC_EN is defined.
module lbfr_read_ctrl #(
  parameter int TX_DATA_WIDTH = 32,
  parameter int SHORT_WC      = 64
) (
  input  logic                       tx_clk_i,
  input  logic                       reset_tx_n_i,
  input  logic                       line_pend_i,
  input  logic [15:0]                wc_i,
  input  logic                       lbfr_halffull_i,
  input  logic                       empty_i,
  input  logic                       word_valid_i,
  input  logic                       lbf_lastwd_i,
  input  logic [TX_DATA_WIDTH-1:0]   byte_i,
  input  logic                       tx_gnt_i,
  output logic                       tx_req_o,
  output logic                       hdr_rd_lbfr_en_o,
  output logic [15:0]                hdr_wdcnt_o,
  output logic                       lp_en_o,
  output logic [TX_DATA_WIDTH-1:0]   data_o,
  output logic                       data_en_o,
  output logic [TX_DATA_WIDTH/8-1:0] data_be_o,
  output logic                       pkt_end_o,
  output logic                       err_o
);
  localparam int BYTES = TX_DATA_WIDTH / 8;
  localparam int SH    = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD, S_PAYLOAD,
`ifdef LBFR_READ_CTRL_CRC_EN
    S_CRC,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        wc_q, wc_d, rd_q, rd_d, cnt_q, cnt_d;
  logic [TX_DATA_WIDTH-1:0] data_q, data_d;
  logic               en_q, en_d, end_q, end_d, err_q, err_d;
  logic [BYTES-1:0]   be_q, be_d, be_last;
  logic [15:0]        rd_words, rem;
  logic               start, last_word;
`ifdef LBFR_READ_CTRL_CRC_EN
  logic [15:0]        crc_q, crc_d;

  // Reflected CRC-16 (0x8408) folded over the enabled bytes of one word, LSB first.
  function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [TX_DATA_WIDTH-1:0] d,
                                          input logic [BYTES-1:0] be);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) begin
        c = c ^ {8'h00, d[8*i +: 8]};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
    end
    return c;
  endfunction
`endif

  // Widen before rounding up so a 0xFFFF count cannot overflow the word count.
  assign rd_words  = 16'(({1'b0, wc_i} + 17'(BYTES - 1)) >> SH);
  assign rem       = wc_q & 16'(BYTES - 1);
  assign be_last   = (rem == 16'd0) ? '1 : BYTES'((32'd1 << rem) - 32'd1);
  assign last_word = (cnt_q + 16'd1 == rd_q);
  assign start     = line_pend_i && (lbfr_halffull_i || (32'(wc_i) <= SHORT_WC && !empty_i));

  // Next-state, line bookkeeping and the one-cycle-delayed output beat.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    en_d    = 1'b0;
    be_d    = '0;
    end_d   = 1'b0;
    err_d   = err_q;
`ifdef LBFR_READ_CTRL_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (!line_pend_i) state_d = S_IDLE;
        else if (tx_gnt_i) begin
          state_d = S_RD;
          wc_d    = wc_i;
          rd_d    = rd_words;
          cnt_d   = 16'd0;
`ifdef LBFR_READ_CTRL_CRC_EN
          crc_d   = 16'hFFFF;
`endif
        end
      end
      S_RD: begin
        if (wc_q != 16'd0) state_d = S_PAYLOAD;
        else begin
`ifdef LBFR_READ_CTRL_CRC_EN
          state_d = S_CRC;
`else
          state_d = S_DONE;
          en_d    = 1'b1;
          end_d   = 1'b1;
`endif
        end
      end
      S_PAYLOAD: begin
        if (word_valid_i) begin
          data_d = byte_i;
          en_d   = 1'b1;
          be_d   = last_word ? be_last : '1;
          cnt_d  = cnt_q + 16'd1;
          if (lbf_lastwd_i && !last_word) err_d = 1'b1;
`ifdef LBFR_READ_CTRL_CRC_EN
          crc_d  = crc_upd(crc_q, byte_i, be_d);
          if (last_word) state_d = S_CRC;
`else
          end_d  = last_word;
          if (last_word) state_d = S_DONE;
`endif
        end
      end
`ifdef LBFR_READ_CTRL_CRC_EN
      S_CRC: begin
        data_d  = TX_DATA_WIDTH'(crc_q);
        be_d    = BYTES'(3);
        en_d    = 1'b1;
        end_d   = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (word_valid_i && state_q != S_PAYLOAD) err_d = 1'b1;
  end

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge tx_clk_i or negedge reset_tx_n_i) begin
    if (!reset_tx_n_i) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      be_q    <= '0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef LBFR_READ_CTRL_CRC_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      be_q    <= be_d;
      end_q   <= end_d;
      err_q   <= err_d;
`ifdef LBFR_READ_CTRL_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign tx_req_o         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign hdr_rd_lbfr_en_o = (state_q == S_RD) && (wc_q != 16'd0);
  assign lp_en_o          = hdr_rd_lbfr_en_o || (state_q == S_PAYLOAD);
  assign hdr_wdcnt_o      = wc_q;
  assign data_o           = data_q;
  assign data_en_o        = en_q;
  assign data_be_o        = be_q;
  assign pkt_end_o        = end_q;
  assign err_o            = err_q;
endmodule

// File: tb/tb_lbfr_read_ctrl.sv
// tb_lbfr_read_ctrl: randomized scoreboard bench for lbfr_read_ctrl.
module tb_lbfr_read_ctrl;
  localparam int W = 32;
  localparam int B = W / 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic line_pend = 1'b0, halffull = 1'b0, empty = 1'b1, wvalid = 1'b0, lastwd = 1'b0, gnt = 1'b0;
  logic [15:0] wc = '0;
  logic [W-1:0] byte_d = '0;
  logic tx_req, hdr_rd, lp_en, data_en, pkt_end, err;
  logic [15:0] hdr_wdcnt;
  logic [W-1:0] data_o;
  logic [B-1:0] be;

  lbfr_read_ctrl #(.TX_DATA_WIDTH(W), .SHORT_WC(64)) dut (
    .tx_clk_i(clk), .reset_tx_n_i(rst_n), .line_pend_i(line_pend), .wc_i(wc),
    .lbfr_halffull_i(halffull), .empty_i(empty), .word_valid_i(wvalid), .lbf_lastwd_i(lastwd),
    .byte_i(byte_d), .tx_gnt_i(gnt), .tx_req_o(tx_req), .hdr_rd_lbfr_en_o(hdr_rd),
    .hdr_wdcnt_o(hdr_wdcnt), .lp_en_o(lp_en), .data_o(data_o), .data_en_o(data_en),
    .data_be_o(be), .pkt_end_o(pkt_end), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] mask;
    logic [B-1:0] be;
    logic         pend;
  } beat_t;

  beat_t sbq[$];
  int checks = 0, errors = 0, pulses = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC: shift register form, one bit at a time.
  function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  // Monitor: every presented beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (hdr_rd) pulses++;
      if (data_en) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with no expected beat", data_o);
        end else begin
          e = sbq.pop_front();
          chk("beat_data", data_o & e.mask, e.data & e.mask);
          chk("beat_be", be, e.be);
          chk("beat_end", pkt_end, e.pend);
        end
      end
    end
  end

  task automatic run_line(input logic [15:0] n, input bit hf, input int lastpos, input int rst_at,
                          input int gap_max);
    int nw, rm, lp, p0;
    logic [7:0] bytes[$];
    logic [W-1:0] w;
    logic [B-1:0] bexp;
    beat_t e;
    nw = (n + B - 1) / B;
    rm = n % B;
    lp = (lastpos < 0) ? nw - 1 : lastpos;
    wc = n;
    line_pend = 1'b1;
    halffull = hf;
    empty = 1'b0;
    for (int i = 0; i < 10 && !tx_req; i++) step();
    chk("tx_req_rise", tx_req, 1);
    if (!tx_req) begin
      line_pend = 1'b0;
      return;
    end
    repeat (3) step();
    chk("tx_req_held", tx_req, 1);
    p0 = pulses;
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    line_pend = 1'b0;
    halffull = 1'b0;
    empty = 1'b1;
    chk("hdr_wdcnt", hdr_wdcnt, n);
    chk("rd_pulse_now", hdr_rd, n != 0);
    chk("lp_en_rd", lp_en, n != 0);
    if (n == 0) begin
`ifndef LBFR_READ_CTRL_CRC_EN
      e.data = '0; e.mask = '0; e.be = '0; e.pend = 1'b1;
      sbq.push_back(e);
`endif
    end else begin
      step();
      for (int i = 0; i < nw; i++) begin
        repeat ($urandom_range(0, gap_max)) step();
        w = $urandom;
        bexp = (i == nw - 1 && rm != 0) ? B'((1 << rm) - 1) : '1;
        wvalid = 1'b1;
        byte_d = w;
        lastwd = (i == lp);
        e.data = w; e.mask = '1; e.be = bexp;
`ifdef LBFR_READ_CTRL_CRC_EN
        e.pend = 1'b0;
`else
        e.pend = (i == nw - 1);
`endif
        sbq.push_back(e);
        for (int k = 0; k < B; k++) if (bexp[k]) bytes.push_back(w[8*k +: 8]);
        step();
        wvalid = 1'b0;
        lastwd = 1'b0;
        if (i == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mid_outputs", {tx_req, hdr_rd, hdr_wdcnt, lp_en, data_en, be, pkt_end, err, data_o}, 0);
          sbq.delete();
          exp_err = 1'b0;
          repeat (2) step();
          rst_n = 1'b1;
          step();
          chk("rst_idle_req", tx_req, 0);
          return;
        end
      end
    end
`ifdef LBFR_READ_CTRL_CRC_EN
    e.data = W'(crc_ref(bytes)); e.mask = W'(16'hFFFF); e.be = B'(3); e.pend = 1'b1;
    sbq.push_back(e);
`endif
    if (n != 0 && lp != nw - 1) exp_err = 1'b1;
    for (int i = 0; i < 10 && tx_req; i++) step();
    chk("tx_req_drop", tx_req, 0);
    step();
    step();
    chk("rd_pulses", pulses - p0, n != 0);
    chk("lp_en_clear", lp_en, 0);
    chk("err", err, exp_err);
  endtask

  initial begin
    logic [15:0] n;
    int p0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {tx_req, hdr_rd, hdr_wdcnt, lp_en, data_en, be, pkt_end, err, data_o}, 0);
    rst_n = 1'b1;
    step();
    wc = 16'd100; halffull = 1'b0; empty = 1'b0; line_pend = 1'b1;
    repeat (4) step();
    chk("no_start_long", tx_req, 0);
    wc = 16'd64; empty = 1'b1;
    repeat (4) step();
    chk("no_start_empty", tx_req, 0);
    wc = 16'd65; empty = 1'b0;
    repeat (4) step();
    chk("no_start_65", tx_req, 0);
    p0 = pulses;
    wc = 16'd64;
    for (int i = 0; i < 10 && !tx_req; i++) step();
    chk("start_short64", tx_req, 1);
    line_pend = 1'b0;
    step();
    chk("abort_req_low", tx_req, 0);
    repeat (3) step();
    chk("abort_no_pulse", pulses - p0, 0);
    run_line(16'd16, 1'b1, -1, -1, 0);
    run_line(16'd10, 1'b0, -1, -1, 2);
    run_line(16'd0, 1'b1, -1, -1, 0);
    for (int t = 0; t < 8; t++) begin
      n = 16'($urandom_range(0, 150));
      run_line(n, (n > 64) ? 1'b1 : 1'($urandom_range(0, 1)), -1, -1, 3);
    end
    run_line(16'd16, 1'b1, 2, -1, 1);
    run_line(16'd12, 1'b1, -1, -1, 1);
    run_line(16'd16, 1'b1, -1, 1, 1);
    chk("err_cleared", err, 0);
    run_line(16'd16, 1'b1, -1, -1, 0);
    run_line(16'hFFFF, 1'b1, -1, -1, 0);
    wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    exp_err = 1'b1;
    chk("err_extra_word", err, exp_err);
    run_line(16'd7, 1'b0, -1, -1, 1);
    repeat (5) step();
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lbfr_read_ctrl.md
LBFR_READ_CTRL -- requirements
Module: lbfr_read_ctrl

Interface
REQ-001 Parameter TX_DATA_WIDTH, default 32, meaning: line buffer read word width in bits (8/16/32/64); BYTES = TX_DATA_WIDTH/8.
REQ-002 Parameter SHORT_WC, default 64, meaning: byte count at or below which a line starts without half-full.
REQ-003 tx_clk_i  in  1  single clock, all logic rising-edge.
REQ-004 reset_tx_n_i  in  1  reset, asynchronous, active-low.
REQ-005 line_pend_i  in  1  line header captured, payload pending in buffer.
REQ-006 wc_i  in  16  pending line byte count.
REQ-007 lbfr_halffull_i, empty_i, word_valid_i, lbf_lastwd_i  in  1 each  line buffer status, read-data strobe, last-word flag.
REQ-008 byte_i  in  TX_DATA_WIDTH  line buffer read data.
REQ-009 tx_gnt_i  in  1  4-to-1 arbiter grant.
REQ-010 tx_req_o  out  1  arbiter request.
REQ-011 hdr_rd_lbfr_en_o  out  1  one-cycle line-read start pulse; hdr_wdcnt_o  out  16  latched byte count.
REQ-012 lp_en_o  out  1  long packet read in progress.
REQ-013 data_o  out  TX_DATA_WIDTH; data_en_o  out  1; data_be_o  out  BYTES  byte enables.
REQ-014 pkt_end_o  out  1  last beat of packet; err_o  out  1  sticky count-mismatch flag.

Function
REQ-015 States IDLE, REQ, RD, PAYLOAD, CRC, DONE; one-hot or encoded at implementer's choice.
REQ-016 IDLE->REQ when line_pend_i=1 and (lbfr_halffull_i=1 or (wc_i<=SHORT_WC and empty_i=0)); tx_req_o=1 from REQ entry until DONE.
REQ-017 REQ: line_pend_i falling -> IDLE with tx_req_o low next cycle; tx_gnt_i=1 -> latch wc_i into hdr_wdcnt_o and rd_words=ceil(wc/BYTES), go RD.
REQ-018 RD: hdr_rd_lbfr_en_o=1 exactly one cycle, lp_en_o set, -> PAYLOAD; if latched wc=0, no pulse, go directly CRC (macro on) or DONE with pkt_end_o=1 single beat, data_be_o=0.
REQ-019 PAYLOAD: each word_valid_i=1 registers byte_i to data_o with data_en_o=1 one cycle later (latency 1); no fixed read latency assumed.
REQ-020 data_be_o all ones except final word: lowest (wc mod BYTES) bits set when remainder nonzero.
REQ-021 PAYLOAD exits when word counter reaches rd_words; lbf_lastwd_i on a different word than rd_words, or word_valid_i after exit, sets err_o; extra words dropped.
REQ-022 pkt_end_o on final payload beat when CRC excluded; lp_en_o cleared on PAYLOAD exit.
REQ-023 DONE lasts one cycle, tx_req_o low, -> IDLE; tx_gnt_i deassertion after REQ ignored.
REQ-024 Word counter 16 bits, no wrap; wc=0xFFFF yields rd_words=ceil(65535/BYTES).

Reset
REQ-025 reset_tx_n_i low: state IDLE, all outputs 0, err_o 0, counters 0, immediately, including mid-packet; no partial packet resumes after release.
REQ-026 err_o cleared only by reset.

Configuration
REQ-027 Macro LBFR_READ_CTRL_CRC_EN defined: CRC state present; CRC-16 (poly 0x8408 reflected, seed 0xFFFF, LSB first) over valid payload bytes only; CRC beat follows payload with data_o[15:0]=CRC, data_be_o=bits[1:0] set, data_en_o=1, pkt_end_o=1.
REQ-028 Macro undefined: no CRC logic, PAYLOAD->DONE, pkt_end_o on last payload word.

Verification
REQ-029 TX_DATA_WIDTH=32, wc=16, halffull=1, grant after 3 cycles -> one hdr_rd_lbfr_en_o pulse, hdr_wdcnt_o=16, 4 beats be=4'hF, pkt_end_o on beat 4 (macro off).
REQ-030 wc=10 -> 3 beats, final be=4'b0011, err_o=0.
REQ-031 Macro on, wc=0 -> no read pulse, single CRC beat data_o[15:0]=16'hFFFF, pkt_end_o=1.
REQ-032 wc=16, lbf_lastwd_i on word 3 -> err_o=1 and remains 1 through next line.
REQ-033 line_pend_i drops in REQ before grant -> tx_req_o low next cycle, no read pulse.
REQ-034 Reset asserted on beat 2 of 4 -> all outputs 0 same cycle, IDLE after release, new line read starts cleanly.
